// File: rtl/vote_collector.sv
// Ballot-collection stage ahead of the majority voter: opens a session on start,
// latches at most one ballot per voter, closes on full turnout or timeout.
module vote_collector #(
    parameter int N       = 7,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] vote_valid,
    input  logic [N-1:0] vote_yes,
    output logic [N-1:0] vote,
    output logic [N-1:0] voted,
    output logic         busy,
    output logic         done,
    output logic         timed_out
);

    localparam int TW = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   vote_q, vote_d;
    logic [N-1:0]   voted_q, voted_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           timed_out_q, timed_out_d;
    logic [N-1:0]   accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vote_q      <= '0;
            voted_q     <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vote_q      <= vote_d;
            voted_q     <= voted_d;
            timer_q     <= timer_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timed_out_q <= timed_out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        vote_d      = vote_q;
        voted_d     = voted_q;
        timer_d     = timer_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        timed_out_d = timed_out_q;
        accept      = vote_valid & ~voted_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = COLLECT;
                    vote_d      = '0;
                    voted_d     = '0;
                    timer_d     = '0;
                    timed_out_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            COLLECT: begin
                // First ballot is final: only voters not yet in the mask are latched.
                voted_d = voted_q | accept;
                vote_d  = (vote_q & ~accept) | (vote_yes & accept);
                if (&voted_d) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    timed_out_d = 1'b0;
                end else if (timer_q == TIMER_LAST) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    timed_out_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign vote      = vote_q;
    assign voted     = voted_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timed_out = timed_out_q;

endmodule

// File: tb/tb_vote_collector.sv
// Self-checking bench for vote_collector: directed session scenarios plus random
// traffic, all checked cycle by cycle against a session-level behavioural model.
module tb_vote_collector;

    localparam int N       = 7;
    localparam int TIMEOUT = 16;
    localparam logic [N-1:0] ALL_VOTED = {N{1'b1}};

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] vote_valid;
    logic [N-1:0] vote_yes;
    logic [N-1:0] vote;
    logic [N-1:0] voted;
    logic         busy;
    logic         done;
    logic         timed_out;

    int checkCount;
    int passCount;

    // Model: phase 0 = idle, 1 = collecting, 2 = closing cycle.
    int           mPhase;
    int           mElapsed;
    logic [N-1:0] mVote;
    logic [N-1:0] mVoted;
    logic         mDone;
    logic         mTimedOut;

    vote_collector #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .vote_valid (vote_valid),
        .vote_yes   (vote_yes),
        .vote       (vote),
        .voted      (voted),
        .busy       (busy),
        .done       (done),
        .timed_out  (timed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic majority(input logic [N-1:0] v);
        int yes = 0;
        for (int i = 0; i < N; i++) yes += int'(v[i]);
        return (yes > N / 2);
    endfunction

    task automatic modelReset();
        mPhase    = 0;
        mElapsed  = 0;
        mVote     = '0;
        mVoted    = '0;
        mDone     = 1'b0;
        mTimedOut = 1'b0;
    endtask

    task automatic modelStep(input logic s, input logic [N-1:0] v, input logic [N-1:0] y);
        mDone = 1'b0;
        case (mPhase)
            0: begin
                if (s) begin
                    mPhase    = 1;
                    mElapsed  = 0;
                    mVote     = '0;
                    mVoted    = '0;
                    mTimedOut = 1'b0;
                end
            end
            1: begin
                mElapsed++;
                for (int i = 0; i < N; i++) begin
                    if (v[i] && !mVoted[i]) begin
                        mVoted[i] = 1'b1;
                        mVote[i]  = y[i];
                    end
                end
                if (mVoted == ALL_VOTED) begin
                    mPhase    = 2;
                    mDone     = 1'b1;
                    mTimedOut = 1'b0;
                end else if (mElapsed == TIMEOUT) begin
                    mPhase    = 2;
                    mDone     = 1'b1;
                    mTimedOut = 1'b1;
                end
            end
            default: mPhase = 0;
        endcase
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, "_vote"}, 32'(vote), 32'(mVote));
        checkOutput({tag, "_voted"}, 32'(voted), 32'(mVoted));
        checkOutput({tag, "_busy"}, 32'(busy), 32'(mPhase == 1));
        checkOutput({tag, "_done"}, 32'(done), 32'(mDone));
        checkOutput({tag, "_timed_out"}, 32'(timed_out), 32'(mTimedOut));
    endtask

    // Drive one cycle of inputs, let the edge happen, then advance the model and compare.
    task automatic applyStimulus(input string tag, input logic s, input logic [N-1:0] v, input logic [N-1:0] y);
        start      = s;
        vote_valid = v;
        vote_yes   = y;
        @(posedge clk);
        #1;
        if (!rst_n) modelReset();
        else        modelStep(s, v, y);
        compareAll(tag);
    endtask

    initial begin
        logic [N-1:0] firstYes;
        logic [N-1:0] rv;
        logic [N-1:0] ry;
        int           doneEdge;

        checkCount = 0;
        passCount  = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        vote_valid = '0;
        vote_yes   = '0;
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Scenario 1: reset state, then one-shot full turnout.
        for (int c = 0; c < 5; c++) applyStimulus("s1_idle", 1'b0, '0, '0);
        checkOutput("s1_reset_voted", 32'(voted), 32'h0);
        applyStimulus("s1_start", 1'b1, '0, '0);
        applyStimulus("s1_ballot", 1'b0, 7'h7F, 7'h0F);
        checkOutput("s1_done", 32'(done), 32'h1);
        checkOutput("s1_vote", 32'(vote), 32'h0F);
        checkOutput("s1_voted", 32'(voted), 32'h7F);
        checkOutput("s1_timed_out", 32'(timed_out), 32'h0);
        checkOutput("s1_pass", 32'(majority(vote)), 32'h1);
        applyStimulus("s1_after", 1'b0, '0, '0);
        checkOutput("s1_done_drop", 32'(done), 32'h0);
        applyStimulus("s1_idle2", 1'b0, '0, '0);

        // Scenario 2: one voter per cycle, voter 2 tries to change its ballot.
        firstYes = N'($urandom);
        applyStimulus("s2_start", 1'b1, '0, '0);
        for (int i = 0; i < N; i++) begin
            applyStimulus("s2_ballot", 1'b0, N'(1) << i, firstYes);
            if (i == 2) applyStimulus("s2_repeat", 1'b0, N'(1) << 2, ~firstYes);
            if (i < N - 1) checkOutput("s2_not_done", 32'(done), 32'h0);
        end
        checkOutput("s2_done_after_7th", 32'(done), 32'h1);
        checkOutput("s2_voter2_first", 32'(vote[2]), 32'(firstYes[2]));
        checkOutput("s2_vote", 32'(vote), 32'(firstYes));
        applyStimulus("s2_after", 1'b0, '0, '0);

        // Scenario 3: partial turnout closes by timeout at E0+16.
        applyStimulus("s3_start", 1'b1, '0, '0);
        doneEdge = -1;
        for (int c = 1; c <= 3 * TIMEOUT && doneEdge < 0; c++) begin
            applyStimulus("s3_wait", 1'b0, (c == 1) ? 7'h07 : 7'h00, 7'h07);
            if (done) doneEdge = c;
        end
        checkOutput("s3_done_edge", 32'(doneEdge), 32'(TIMEOUT));
        checkOutput("s3_vote", 32'(vote), 32'h07);
        checkOutput("s3_voted", 32'(voted), 32'h07);
        checkOutput("s3_timed_out", 32'(timed_out), 32'h1);
        checkOutput("s3_pass", 32'(majority(vote)), 32'h0);
        applyStimulus("s3_after", 1'b0, '0, '0);

        // Scenario 4: last voter arrives on the timeout cycle.
        applyStimulus("s4_start", 1'b1, '0, '0);
        applyStimulus("s4_early", 1'b0, 7'h3F, N'($urandom));
        for (int c = 2; c < TIMEOUT; c++) begin
            applyStimulus("s4_wait", 1'b0, '0, '0);
            checkOutput("s4_still_busy", 32'(busy), 32'h1);
        end
        applyStimulus("s4_last", 1'b0, 7'h40, 7'h40);
        checkOutput("s4_done", 32'(done), 32'h1);
        checkOutput("s4_voted", 32'(voted), 32'h7F);
        checkOutput("s4_timed_out", 32'(timed_out), 32'h0);
        applyStimulus("s4_after", 1'b0, '0, '0);

        // Scenario 5: start during COLLECT and DONE is ignored.
        applyStimulus("s5_start", 1'b1, '0, '0);
        applyStimulus("s5_ballot", 1'b1, 7'h10, 7'h10);
        doneEdge = -1;
        for (int c = 2; c <= 3 * TIMEOUT && doneEdge < 0; c++) begin
            applyStimulus("s5_wait", c[0], '0, '0);
            if (done) doneEdge = c;
        end
        checkOutput("s5_done_edge", 32'(doneEdge), 32'(TIMEOUT));
        checkOutput("s5_timed_out", 32'(timed_out), 32'h1);
        applyStimulus("s5_start_in_done", 1'b1, '0, '0);
        checkOutput("s5_no_restart", 32'(busy), 32'h0);
        checkOutput("s5_voted_held", 32'(voted), 32'h10);
        applyStimulus("s5_restart", 1'b1, '0, '0);
        checkOutput("s5_busy", 32'(busy), 32'h1);
        checkOutput("s5_cleared_voted", 32'(voted), 32'h0);
        checkOutput("s5_cleared_timed_out", 32'(timed_out), 32'h0);
        applyStimulus("s5_finish", 1'b0, 7'h7F, 7'h55);
        checkOutput("s5_vote", 32'(vote), 32'h55);
        applyStimulus("s5_after", 1'b0, '0, '0);

        // Scenario 6: asynchronous reset mid-session.
        applyStimulus("s6_start", 1'b1, '0, '0);
        applyStimulus("s6_ballot", 1'b0, 7'h0F, 7'h0B);
        applyStimulus("s6_wait", 1'b0, '0, '0);
        checkOutput("s6_voted_before", 32'(voted), 32'h0F);
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        compareAll("s6_async");
        checkOutput("s6_busy_now", 32'(busy), 32'h0);
        checkOutput("s6_voted_now", 32'(voted), 32'h0);
        applyStimulus("s6_in_reset", 1'b0, 7'h7F, 7'h7F);
        checkOutput("s6_no_done", 32'(done), 32'h0);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) applyStimulus("s6_nostart", 1'b0, 7'h7F, 7'h7F);
        checkOutput("s6_stay_zero", 32'(voted), 32'h0);

        // Random traffic: sparse ballots, occasional start requests.
        for (int c = 0; c < 600; c++) begin
            rv = N'($urandom) & N'($urandom) & N'($urandom);
            ry = N'($urandom);
            applyStimulus("rand", ($urandom_range(0, 3) == 0), rv, ry);
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
